// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM encoding, PC step and reset vector.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // jalr targets are always halfword aligned; bit 1 is left for the trap check
  function automatic logic [31:0] jalr_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/pc_sequencer_newpc.sv
// NewPC block: redirect target adder, base plus sign-extended offset modulo 2^32.
module pc_sequencer_newpc (
  input  logic [31:0] pc,
  input  logic [31:0] immExt,
  output logic [31:0] newpc
);

  assign newpc = pc + immExt;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch with handshake, branch/jalr redirect,
// halt and sticky misaligned-target trap.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic        jalr,
  input  logic [31:0] brPc,
  input  logic [31:0] rs1,
  input  logic [31:0] immExt,
  input  logic        halt,
  input  logic        imemAck,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic [31:0] pc,
  output logic        instrValid,
  output logic        misaligned,
  output logic [15:0] fetchCnt
);

  state_t      state;
  logic        active;
  logic        redirect;
  logic        fetch_done;
  logic [31:0] adder_base;
  logic [31:0] adder_sum;
  logic [31:0] target;

  assign active     = (state == ST_IDLE) || (state == ST_REQ);
  assign redirect   = active && (jalr || branchTaken);
  assign adder_base = jalr ? rs1 : brPc;

  pc_sequencer_newpc u_newpc (
    .pc     (adder_base),
    .immExt (immExt),
    .newpc  (adder_sum)
  );

  assign target     = jalr ? jalr_align(adder_sum) : adder_sum;
  assign imemReq    = (state == ST_REQ) && !stall;
  assign imemAddr   = pc;
  // halt and redirect both cancel a same-cycle ack
  assign fetch_done = imemReq && imemAck && !redirect && !halt;
  assign instrValid = fetch_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_VECTOR;
      fetchCnt   <= 16'd0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_REQ: begin
          if (halt) begin
            state <= ST_HALT;
          end else if (redirect) begin
            pc <= target;
            if (target[1]) begin
              state      <= ST_TRAP;
              misaligned <= 1'b1;
            end else begin
              state <= ST_REQ;
            end
          end else if (fetch_done) begin
            pc       <= pc + PC_INC;
            fetchCnt <= fetchCnt + 16'd1;
            state    <= ST_REQ;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_HALT, ST_TRAP: begin
          state <= state;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected per-cycle outputs are queued when
// stimulus is applied and popped mid-cycle for comparison.
module tb_pc_sequencer;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        jalr;
    logic        halt;
    logic        ack;
    logic [31:0] brpc;
    logic [31:0] rs1;
    logic [31:0] imm;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        req;
    logic        iv;
    logic [15:0] cnt;
    logic        mis;
  } obs_t;

  logic        clk;
  logic        rst_n, stall, branchTaken, jalr, halt, imemAck;
  logic [31:0] brPc, rs1, immExt;
  logic        req0, iv0, mis0, req1, iv1, mis1;
  logic [31:0] addr0, pc0, addr1, pc1;
  logic [15:0] cnt0, cnt1;

  obs_t sb[$];
  obs_t sb_w[$];
  int   checks = 0;
  int   errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branchTaken(branchTaken), .jalr(jalr),
    .brPc(brPc), .rs1(rs1), .immExt(immExt), .halt(halt), .imemAck(imemAck),
    .imemReq(req0), .imemAddr(addr0), .pc(pc0), .instrValid(iv0),
    .misaligned(mis0), .fetchCnt(cnt0)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branchTaken(branchTaken), .jalr(jalr),
    .brPc(brPc), .rs1(rs1), .immExt(immExt), .halt(halt), .imemAck(imemAck),
    .imemReq(req1), .imemAddr(addr1), .pc(pc1), .instrValid(iv1),
    .misaligned(mis1), .fetchCnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(input logic r, input logic sl, input logic b, input logic j,
                               input logic h, input logic a, input logic [31:0] bp,
                               input logic [31:0] r1, input logic [31:0] im);
    st = '{r, sl, b, j, h, a, bp, r1, im};
  endfunction

  function automatic obs_t mk(input logic [31:0] p, input logic rq, input logic v,
                              input logic [15:0] c, input logic m);
    mk = '{p, p, rq, v, c, m};
  endfunction

  function automatic obs_t obs_main();
    obs_main = '{pc0, addr0, req0, iv0, cnt0, mis0};
  endfunction

  function automatic obs_t obs_wrap();
    obs_wrap = '{pc1, addr1, req1, iv1, cnt1, mis1};
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = s.rst_n; stall = s.stall; branchTaken = s.br; jalr = s.jalr;
    halt = s.halt; imemAck = s.ack; brPc = s.brpc; rs1 = s.rs1; immExt = s.imm;
  endtask

  task automatic apply_reset();
    drive(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0));
    drive(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0));
  endtask

  // two reset cycles, one IDLE cycle, then four back-to-back fetches
  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 7; i++) begin
      drive(st(i >= 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0));
      if (i >= 1) begin
        if (i <= 2) sb.push_back(mk(32'd0, 1'b0, 1'b0, 16'd0, 1'b0));
        else        sb.push_back(mk(32'(4 * (i - 3)), 1'b1, 1'b1, 16'(i - 3), 1'b0));
        #2;
        e = sb.pop_front();
        o = obs_main();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL reset_fetch[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                   i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
        end
      end
    end
  endtask

  // pc=10: three cycles without ack, then two acked fetches
  task automatic test_back_pressure();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      drive(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i >= 3, 32'd0, 32'd0, 32'd0));
      if (i < 3)       sb.push_back(mk(32'h10, 1'b1, 1'b0, 16'd4, 1'b0));
      else if (i == 3) sb.push_back(mk(32'h10, 1'b1, 1'b1, 16'd4, 1'b0));
      else             sb.push_back(mk(32'h14, 1'b1, 1'b1, 16'd5, 1'b0));
      #2;
      e = sb.pop_front();
      o = obs_main();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_pressure[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                 i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
      end
    end
  endtask

  task automatic test_branch_stall();
    obs_t e, o;
    stim_t s [6];
    obs_t  x [6];
    s[0] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    s[1] = s[0];
    s[2] = st(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'd0, 32'hFFFF_FFFC);
    s[3] = st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    s[4] = s[0];
    s[5] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    x[0] = mk(32'h0, 1'b1, 1'b1, 16'd0, 1'b0);
    x[1] = mk(32'h4, 1'b1, 1'b1, 16'd1, 1'b0);
    x[2] = mk(32'h8, 1'b0, 1'b0, 16'd2, 1'b0);
    x[3] = mk(32'h4, 1'b0, 1'b0, 16'd2, 1'b0);
    x[4] = mk(32'h4, 1'b1, 1'b1, 16'd2, 1'b0);
    x[5] = mk(32'h8, 1'b1, 1'b0, 16'd3, 1'b0);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      #2;
      e = sb.pop_front();
      o = obs_main();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch_stall[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                 i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
      end
    end
  endtask

  // from pc=8: jalr to 0x101+2 -> 0x102 traps; then 10 cycles of ignored inputs
  task automatic test_jalr_trap();
    obs_t e, o;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) drive(st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h101, 32'h2));
      else        drive(st(1'b1, i[2], i[0], i == 5, 1'b0, 1'b1, 32'h40, 32'h200, 32'h4));
      if (i == 0) sb.push_back(mk(32'h8, 1'b1, 1'b0, 16'd3, 1'b0));
      else        sb.push_back(mk(32'h102, 1'b0, 1'b0, 16'd3, 1'b1));
      #2;
      e = sb.pop_front();
      o = obs_main();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jalr_trap[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                 i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
      end
    end
  endtask

  // jalr wins over branch; then a branch to a bit-1 target traps
  task automatic test_jalr_priority();
    obs_t e, o;
    stim_t s [4];
    obs_t  x [4];
    s[0] = st(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h20, 32'h1);
    s[1] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    s[2] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 32'h12);
    s[3] = s[1];
    x[0] = mk(32'h0,  1'b1, 1'b0, 16'd0, 1'b0);
    x[1] = mk(32'h20, 1'b1, 1'b1, 16'd0, 1'b0);
    x[2] = mk(32'h24, 1'b1, 1'b0, 16'd1, 1'b0);
    x[3] = mk(32'h32, 1'b0, 1'b0, 16'd1, 1'b1);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      sb.push_back(x[i]);
      #2;
      e = sb.pop_front();
      o = obs_main();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jalr_priority[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                 i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
      end
    end
  endtask

  // halt beats branch at pc=C; HALT ignores everything until reset
  task automatic test_halt();
    obs_t e, o;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 3)       drive(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0));
      else if (i == 3) drive(st(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h40));
      else if (i < 7)  drive(st(1'b1, i[0], 1'b1, i[1], 1'b0, 1'b1, 32'h80, 32'h80, 32'h8));
      else if (i == 7) drive(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0));
      else             drive(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0));
      if (i < 3)       sb.push_back(mk(32'(4 * i), 1'b1, 1'b1, 16'(i), 1'b0));
      else if (i == 3) sb.push_back(mk(32'hC, 1'b1, 1'b0, 16'd3, 1'b0));
      else if (i < 8)  sb.push_back(mk(32'hC, 1'b0, 1'b0, 16'd3, 1'b0));
      else if (i == 8) sb.push_back(mk(32'h0, 1'b0, 1'b0, 16'd0, 1'b0));
      else             sb.push_back(mk(32'h0, 1'b1, 1'b1, 16'd0, 1'b0));
      #2;
      e = sb.pop_front();
      o = obs_main();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                 i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
      end
    end
  endtask

  // second instance with RESET_VECTOR=FFFF_FFF8 crosses the 2^32 boundary
  task automatic test_wrap();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      drive(st(i >= 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0));
      if (i >= 1) begin
        if (i == 1) sb_w.push_back(mk(32'hFFFF_FFF8, 1'b0, 1'b0, 16'd0, 1'b0));
        else        sb_w.push_back(mk(32'hFFFF_FFF8 + 32'(4 * (i - 2)), 1'b1, 1'b1, 16'(i - 2), 1'b0));
        #2;
        e = sb_w.pop_front();
        o = obs_wrap();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL wrap[%0d]: got pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b, want pc=%h addr=%h req=%b iv=%b cnt=%0d mis=%b",
                   i, o.pc, o.addr, o.req, o.iv, o.cnt, o.mis, e.pc, e.addr, e.req, e.iv, e.cnt, e.mis);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; jalr = 1'b0; halt = 1'b0;
    imemAck = 1'b0; brPc = 32'd0; rs1 = 32'd0; immExt = 32'd0;
    test_reset();
    test_back_pressure();
    test_branch_stall();
    test_jalr_trap();
    test_jalr_priority();
    test_halt();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
